// File: rtl/free_list_pkg.sv
// Shared configuration for the physical-register free list: depth, pointer
// width, architectural register count and the reset fill count.
package free_list_pkg;

  localparam int unsigned PROJ_LOG_PHYS      = 6;
  localparam int unsigned PROJ_NUM_PHYS_REGS = 64;
  localparam int unsigned PROJ_NUM_ARCH_REGS = 32;

  // Pointers carry one extra wrap bit above the index.
  localparam int unsigned PTR_W      = PROJ_LOG_PHYS + 1;
  // Registers free at reset: everything not mapped to an architectural reg.
  localparam int unsigned RESET_FILL = PROJ_NUM_PHYS_REGS - PROJ_NUM_ARCH_REGS;

  typedef logic [PTR_W-1:0]         ptr_t;
  typedef logic [PROJ_LOG_PHYS-1:0] preg_t;

endpackage

// File: rtl/free_list_bitmap.sv
// Per-physical-register "currently free" bitmap used to catch double frees.
// Registers above the architectural range start out free; reg 0 never is.
module free_list_bitmap
  import free_list_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     set_en,
  input  logic [PROJ_LOG_PHYS-1:0] set_reg,
  input  logic                     clr_en,
  input  logic [PROJ_LOG_PHYS-1:0] clr_reg,
  input  logic [PROJ_LOG_PHYS-1:0] query_reg,
  output logic                     query_hit
);

  localparam logic [PROJ_NUM_PHYS_REGS-1:0] RST_MAP =
    {{RESET_FILL{1'b1}}, {PROJ_NUM_ARCH_REGS{1'b0}}};

  logic [PROJ_NUM_PHYS_REGS-1:0] bits_q;

  // Clear on commit of an allocation, set on an accepted free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bits_q <= RST_MAP;
    end else begin
      if (clr_en) bits_q[clr_reg] <= 1'b0;
      if (set_en) bits_q[set_reg] <= 1'b1;
    end
  end

  assign query_hit = bits_q[query_reg];

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for rename. Head pops to rename,
// tail takes retired stale registers, committed head supports flush recovery.
// Optional build macro FREE_LIST_DOUBLE_FREE_CHECK_EN adds a double-free
// bitmap and the sticky Double_free_err output.
module free_list
  import free_list_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Grabbed_regs,
  output logic [PROJ_LOG_PHYS-1:0] Free_phys_reg,
  output logic                     Free_reg_avail,
  output logic [PROJ_LOG_PHYS:0]   Free_count,
  input  logic                     Retire_free_valid,
  input  logic [PROJ_LOG_PHYS-1:0] Retire_free_reg,
  input  logic                     Commit_alloc,
  input  logic                     Flush,
  output logic                     Overflow_err
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  ,
  output logic                     Double_free_err
`endif
);

  ptr_t  head_q, tail_q, chead_q;
  preg_t mem_q [PROJ_NUM_PHYS_REGS];

  ptr_t  count_c, chead_nxt_c, head_nxt_c, tail_nxt_c;
  logic  full_c, push_req_c, push_ok_c, pop_ok_c, commit_ok_c, dbl_hit_c;

  // Occupancy and head-entry outputs derive only from registered state.
  assign count_c        = tail_q - head_q;
  assign full_c         = (count_c == PTR_W'(PROJ_NUM_PHYS_REGS));
  assign Free_count     = count_c;
  assign Free_reg_avail = (count_c != '0);
  assign Free_phys_reg  = mem_q[head_q[PROJ_LOG_PHYS-1:0]];

  // Accept/ignore decisions for this cycle's requests.
  assign push_req_c  = Retire_free_valid && (Retire_free_reg != '0);
  assign push_ok_c   = push_req_c && !full_c && !dbl_hit_c;
  assign pop_ok_c    = Grabbed_regs && Free_reg_avail && !Flush;
  assign commit_ok_c = Commit_alloc && (chead_q != head_q);

  // Next pointers; flush restores head to the (possibly advanced) commit point.
  assign chead_nxt_c = chead_q + PTR_W'(commit_ok_c);
  assign head_nxt_c  = Flush ? chead_nxt_c : (head_q + PTR_W'(pop_ok_c));
  assign tail_nxt_c  = tail_q + PTR_W'(push_ok_c);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  free_list_bitmap u_bitmap (
    .CLK       (CLK),
    .RESET     (RESET),
    .set_en    (push_ok_c),
    .set_reg   (Retire_free_reg),
    .clr_en    (commit_ok_c),
    .clr_reg   (mem_q[chead_q[PROJ_LOG_PHYS-1:0]]),
    .query_reg (Retire_free_reg),
    .query_hit (dbl_hit_c)
  );

  // Sticky flag for a free of a register that is already on the list.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) Double_free_err <= 1'b0;
    else if (push_req_c && dbl_hit_c) Double_free_err <= 1'b1;
  end
`else
  assign dbl_hit_c = 1'b0;
`endif

  // Pointer update and sticky overflow flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q       <= '0;
      chead_q      <= '0;
      tail_q       <= PTR_W'(RESET_FILL);
      Overflow_err <= 1'b0;
    end else begin
      head_q  <= head_nxt_c;
      chead_q <= chead_nxt_c;
      tail_q  <= tail_nxt_c;
      if (push_req_c && full_c) Overflow_err <= 1'b1;
    end
  end

  // Entry storage: reset preloads the non-architectural registers in order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < PROJ_NUM_PHYS_REGS; i++) begin
        mem_q[PROJ_LOG_PHYS'(i)] <= (i < RESET_FILL) ?
                                    PROJ_LOG_PHYS'(PROJ_NUM_ARCH_REGS + i) : '0;
      end
    end else if (push_ok_c) begin
      mem_q[tail_q[PROJ_LOG_PHYS-1:0]] <= Retire_free_reg;
    end
  end

endmodule
